nic: RTL and testbench
======================

NIC -- requirements
Module: nic

Interface
Parameters:
REQ-001 DATA_WIDTH, default 64, packet width; bit 63 is the virtual-channel (VC) bit.
REQ-002 ADDR_WIDTH, default 2, processor register-address width.

Ports:
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 addr  input  2  processor register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status.
REQ-006 d_in  input  64  processor write data.
REQ-007 d_out  output  64  processor read data, registered.
REQ-008 nicEn  input  1  processor access enable.
REQ-009 nicWrEn  input  1  write when 1, read when 0; qualified by nicEn.
REQ-010 net_si  output  1  send request to the router PE input port (pesi).
REQ-011 net_ri  input  1  router PE input port ready (peri).
REQ-012 net_do  output  64  packet to the router (pedi).
REQ-013 net_so  input  1  router PE output port send (peso).
REQ-014 net_ro  output  1  NIC ready to accept a router packet (pero).
REQ-015 net_di  input  64  packet from the router (pedo).
REQ-016 net_polarity  input  1  router polarity bit.

Function
REQ-017 Two one-entry buffers SHALL exist: out_buf (PE to router) and in_buf (router to PE), each with a full flag.
REQ-018 net_ro SHALL equal ~in_full, combinationally.
REQ-019 When net_so=1 and net_ro=1 at a clock edge, in_buf SHALL capture net_di and in_full SHALL become 1.
REQ-020 A read of addr 00 (nicEn=1, nicWrEn=0) SHALL load in_buf into d_out on the next edge and clear in_full at that edge if in_full was 1.
REQ-021 A read of addr 00 while in_full=0 SHALL return the stale in_buf contents and change no state.
REQ-022 A read of addr 01 SHALL return {63'b0, in_full}; a read of addr 11 SHALL return {63'b0, out_full}.
REQ-023 A read of addr 10 SHALL return the out_buf contents without side effect.
REQ-024 d_out SHALL hold its value on any cycle with no read.
REQ-025 A write to addr 10 while out_full=0 SHALL load d_in into out_buf and set out_full to 1.
REQ-026 A write to addr 10 while out_full=1 (the value sampled at the start of the cycle) SHALL be dropped, even if out_buf drains in that same cycle.
REQ-027 Writes to addrs 00, 01 and 11 SHALL be ignored.
REQ-028 net_si SHALL equal out_full AND (out_buf[63] == net_polarity); net_do SHALL equal out_buf at all times.
REQ-029 When net_si=1 and net_ri=1 at a clock edge, out_full SHALL clear; otherwise out_buf SHALL hold, and this hold is not an error.
REQ-030 Latency: a router packet SHALL be visible in in-status one cycle after its handshake edge, and readable on d_out one cycle after the read cycle.

Reset
REQ-031 While reset=0 at a rising edge: in_full=0, out_full=0, d_out=0, and in_buf and out_buf SHALL clear to 0.
REQ-032 A reset asserted mid-transfer SHALL discard buffered packets without completing any handshake.
REQ-033 net_si=0 and net_ro=1 SHALL hold from the first post-reset cycle.

Configuration
REQ-034 With NIC_PKT_CNT_EN defined, 8-bit wrapping counters of sent and received packets SHALL appear in status bits [15:8] of addr 11 and addr 01 respectively; both counters SHALL increment on their handshake edge, wrap from 255 to 0, and reset to 0.
REQ-035 With NIC_PKT_CNT_EN undefined, no counters SHALL exist and status bits [15:8] SHALL read 0.

Structure
REQ-036 Shared package nic_pkg SHALL hold DATA_WIDTH, the VC-bit index (63), and the four register-address constants.
REQ-037 Sub-module nic_buf SHALL implement one 64-bit entry with load, clear and full; it SHALL be instantiated twice.

Verification
REQ-038 Reset, then read addr 01 and addr 11 -> both return 0; net_ro=1, net_si=0.
REQ-039 Write 64'h8000_0000_0000_00AA to addr 10 with net_polarity=0 then 1 and net_ri=1 -> net_si=0 while polarity=0; net_si=1 when polarity=1; out_full clears after that edge.
REQ-040 Write 64'h1 then 64'h2 to addr 10 with net_ri=0 -> out_buf holds 64'h1 and the second write is dropped.
REQ-041 Router sends 64'h0000_0000_0000_0055 -> net_ro drops next cycle; addr 01 reads 1; read of addr 00 returns 64'h55; net_ro returns to 1.
REQ-042 A second net_so while in_full=1 -> no capture; the first packet is preserved.
REQ-043 With NIC_PKT_CNT_EN, 257 send handshakes -> addr 11 bits [15:8] read 8'h01.

Source files
------------

// File: rtl/nic_pkg.sv
// -----------------------------------------------------------------------------
// nic_pkg: shared constants and helpers for the network interface controller.
//   DATA_WIDTH      - packet / register width
//   VC_BIT          - bit index of the virtual-channel bit in a packet
//   CNT_WIDTH       - width of the optional packet counters
//   ADDR_*          - processor register-address map
//   status_word()   - builds a status register image {cnt[15:8], full[0]}
// -----------------------------------------------------------------------------
package nic_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int VC_BIT     = 63;
    localparam int CNT_WIDTH  = 8;

    localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    // Status image: full flag in bit 0, packet count in bits [15:8], rest zero.
    function automatic logic [DATA_WIDTH-1:0] status_word(input logic                 full,
                                                          input logic [CNT_WIDTH-1:0] cnt);
        logic [DATA_WIDTH-1:0] w;
        w       = {DATA_WIDTH{1'b0}};
        w[0]    = full;
        w[15:8] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/nic_buf.sv
// -----------------------------------------------------------------------------
// nic_buf: one-entry packet buffer with a full flag.
//   clk     in  clock
//   reset   in  synchronous active-low reset (clears data and full)
//   load_i  in  capture data_i and mark full
//   clr_i   in  mark empty (data is kept, so a later read sees stale contents)
//   data_i  in  packet to capture
//   data_o  out stored packet
//   full_o  out entry holds an unconsumed packet
// load_i wins over clr_i; the instantiating logic never asserts both together.
// -----------------------------------------------------------------------------
module nic_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= {WIDTH{1'b0}};
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/nic.sv
// -----------------------------------------------------------------------------
// nic: network interface controller between a processor register port and a
// router PE port. One outbound entry (processor -> router) and one inbound
// entry (router -> processor).
//   clk, reset          clock, synchronous active-low reset
//   addr, d_in, d_out   processor register select, write data, registered read data
//   nicEn, nicWrEn      access enable, write(1)/read(0)
//   net_si/net_ri/net_do  outbound send request, router ready, packet
//   net_so/net_ro/net_di  inbound router send, NIC ready, packet
//   net_polarity        router polarity; outbound packets only go when their
//                       VC bit matches it
// Optional feature macro NIC_PKT_CNT_EN: 8-bit wrapping sent/received packet
// counters shown in bits [15:8] of the out/in status registers. Without it those
// bits read zero.
// -----------------------------------------------------------------------------
module nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_si,
    input  logic                  net_ri,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_so,
    output logic                  net_ro,
    input  logic [DATA_WIDTH-1:0] net_di,
    input  logic                  net_polarity
);

    import nic_pkg::*;

    logic                  rd_s;
    logic                  wr_s;
    logic                  in_load_s;
    logic                  in_clr_s;
    logic                  in_full_s;
    logic [DATA_WIDTH-1:0] in_data_s;
    logic                  out_load_s;
    logic                  out_clr_s;
    logic                  out_full_s;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic [CNT_WIDTH-1:0]  sent_cnt_s;
    logic [CNT_WIDTH-1:0]  rcvd_cnt_s;
    logic [DATA_WIDTH-1:0] d_out_d;
    logic [DATA_WIDTH-1:0] d_out_q;

    assign rd_s = nicEn & ~nicWrEn;
    assign wr_s = nicEn & nicWrEn;

    // Router-facing handshakes. The in entry only captures while empty, and the
    // out entry only drains while its VC bit matches the current polarity.
    assign net_ro    = ~in_full_s;
    assign net_si    = out_full_s & (out_data_s[VC_BIT] == net_polarity);
    assign net_do    = out_data_s;
    assign in_load_s = net_so & ~in_full_s;
    assign out_clr_s = net_si & net_ri;

    // Processor write: only the out-data register is writable, and only when
    // the entry was empty at the start of the cycle (a same-cycle drain does
    // not make room).
    always_comb begin
        out_load_s = 1'b0;
        if (wr_s && (addr == ADDR_OUT_DATA) && !out_full_s) begin
            out_load_s = 1'b1;
        end else begin
            out_load_s = 1'b0;
        end
    end

    // Processor read mux; reading in-data consumes the inbound packet if one is held.
    always_comb begin
        d_out_d  = d_out_q;
        in_clr_s = 1'b0;
        if (rd_s) begin
            case (addr)
                ADDR_IN_DATA: begin
                    d_out_d  = in_data_s;
                    in_clr_s = in_full_s;
                end
                ADDR_IN_STATUS:  d_out_d = DATA_WIDTH'(status_word(in_full_s, rcvd_cnt_s));
                ADDR_OUT_DATA:   d_out_d = out_data_s;
                ADDR_OUT_STATUS: d_out_d = DATA_WIDTH'(status_word(out_full_s, sent_cnt_s));
                default:         d_out_d = d_out_q;
            endcase
        end else begin
            d_out_d = d_out_q;
        end
    end

    // Registered read data; holds when no read is issued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            d_out_q <= {DATA_WIDTH{1'b0}};
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

    nic_buf #(.WIDTH(DATA_WIDTH)) u_in_buf (
        .clk    (clk),
        .reset  (reset),
        .load_i (in_load_s),
        .clr_i  (in_clr_s),
        .data_i (net_di),
        .data_o (in_data_s),
        .full_o (in_full_s)
    );

    nic_buf #(.WIDTH(DATA_WIDTH)) u_out_buf (
        .clk    (clk),
        .reset  (reset),
        .load_i (out_load_s),
        .clr_i  (out_clr_s),
        .data_i (d_in),
        .data_o (out_data_s),
        .full_o (out_full_s)
    );

`ifdef NIC_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] sent_cnt_q;
    logic [CNT_WIDTH-1:0] rcvd_cnt_q;

    // Wrapping packet counters, stepped on each completed router handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sent_cnt_q <= {CNT_WIDTH{1'b0}};
            rcvd_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            if (out_clr_s) begin
                sent_cnt_q <= sent_cnt_q + 8'd1;
            end
            if (in_load_s) begin
                rcvd_cnt_q <= rcvd_cnt_q + 8'd1;
            end
        end
    end

    assign sent_cnt_s = sent_cnt_q;
    assign rcvd_cnt_s = rcvd_cnt_q;
`else
    assign sent_cnt_s = {CNT_WIDTH{1'b0}};
    assign rcvd_cnt_s = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_nic.sv
// -----------------------------------------------------------------------------
// tb_nic: self-checking bench for nic. A transaction-level model tracks the two
// one-entry mailboxes, the read-data register and the packet counts; directed
// scenarios and randomized traffic are compared against it.
// -----------------------------------------------------------------------------
module tb_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = 64'd0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_si;
    logic        net_ri = 1'b0;
    logic [63:0] net_do;
    logic        net_so = 1'b0;
    logic        net_ro;
    logic [63:0] net_di = 64'd0;
    logic        net_polarity = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_in_full  = 1'b0;
    logic        m_out_full = 1'b0;
    logic [63:0] m_in_buf   = 64'd0;
    logic [63:0] m_out_buf  = 64'd0;
    logic [63:0] m_dout     = 64'd0;
    int          m_sent     = 0;
    int          m_rcvd     = 0;

    nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_do       (net_do),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_di       (net_di),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m_status(input logic full, input int cnt);
        logic [63:0] w;
        w    = 64'd0;
        w[0] = full;
`ifdef NIC_PKT_CNT_EN
        w[15:8] = cnt[7:0];
`endif
        return w;
    endfunction

    function automatic logic m_si();
        return m_out_full && (m_out_buf[63] == net_polarity);
    endfunction

    // Advance one clock: predict the effect of the current inputs, then step.
    task automatic tick();
        logic        n_in_full, n_out_full;
        logic [63:0] n_in_buf, n_out_buf, n_dout;
        int          n_sent, n_rcvd;
        n_in_full = m_in_full; n_out_full = m_out_full;
        n_in_buf  = m_in_buf;  n_out_buf  = m_out_buf;
        n_dout    = m_dout;    n_sent     = m_sent; n_rcvd = m_rcvd;
        if (!reset) begin
            n_in_full = 1'b0; n_out_full = 1'b0;
            n_in_buf  = 64'd0; n_out_buf = 64'd0; n_dout = 64'd0;
            n_sent    = 0; n_rcvd = 0;
        end else begin
            if (nicEn && !nicWrEn) begin
                case (addr)
                    2'd0: begin n_dout = m_in_buf; n_in_full = 1'b0; end
                    2'd1: n_dout = m_status(m_in_full, m_rcvd);
                    2'd2: n_dout = m_out_buf;
                    default: n_dout = m_status(m_out_full, m_sent);
                endcase
            end
            if (nicEn && nicWrEn && addr == 2'd2 && !m_out_full) begin
                n_out_buf = d_in; n_out_full = 1'b1;
            end
            if (m_si() && net_ri) begin
                n_out_full = 1'b0; n_sent = m_sent + 1;
            end
            if (net_so && !m_in_full) begin
                n_in_buf = net_di; n_in_full = 1'b1; n_rcvd = m_rcvd + 1;
            end
        end
        @(posedge clk);
        #1;
        m_in_full = n_in_full; m_out_full = n_out_full;
        m_in_buf  = n_in_buf;  m_out_buf  = n_out_buf;
        m_dout    = n_dout;    m_sent     = n_sent; m_rcvd = n_rcvd;
    endtask

    task automatic idle();
        nicEn = 1'b0; nicWrEn = 1'b0; net_so = 1'b0; net_ri = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must dominate any traffic presented alongside it.
        reset = 1'b0; net_so = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'h1234;
        tick(); tick();
        reset = 1'b1; idle(); #1;
        total += 4;
        if (d_out !== 64'd0)  begin bad++; $display("FAIL reset_d_out: got %h want %h", d_out, 64'd0); end
        if (net_si !== 1'b0)  begin bad++; $display("FAIL reset_net_si: got %b want 0", net_si); end
        if (net_ro !== 1'b1)  begin bad++; $display("FAIL reset_net_ro: got %b want 1", net_ro); end
        if (net_do !== 64'd0) begin bad++; $display("FAIL reset_net_do: got %h want 0", net_do); end
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd1; tick();
        total++;
        if (d_out !== 64'd0) begin bad++; $display("FAIL reset_in_status: got %h want 0", d_out); end
        addr = 2'd3; tick();
        total++;
        if (d_out !== 64'd0) begin bad++; $display("FAIL reset_out_status: got %h want 0", d_out); end
        idle();
    endtask

    task automatic test_polarity();
        idle(); net_polarity = 1'b0; net_ri = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'h8000_0000_0000_00AA;
        tick();
        nicEn = 1'b0; #1;
        total += 2;
        if (net_si !== 1'b0) begin bad++; $display("FAIL pol0_si: got %b want 0", net_si); end
        if (net_do !== 64'h8000_0000_0000_00AA) begin bad++; $display("FAIL pol_net_do: got %h want %h", net_do, 64'h8000_0000_0000_00AA); end
        tick();
        total++;
        if (net_si !== 1'b0) begin bad++; $display("FAIL pol0_hold_si: got %b want 0", net_si); end
        net_polarity = 1'b1; #1;
        total++;
        if (net_si !== 1'b1) begin bad++; $display("FAIL pol1_si: got %b want 1", net_si); end
        tick();
        total++;
        if (net_si !== 1'b0) begin bad++; $display("FAIL pol_drained_si: got %b want 0", net_si); end
        net_ri = 1'b0; nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd3; tick();
        total += 2;
        if (d_out[0] !== 1'b0) begin bad++; $display("FAIL pol_out_full: got %b want 0", d_out[0]); end
        if (d_out !== m_dout)  begin bad++; $display("FAIL pol_out_status: got %h want %h", d_out, m_dout); end
        idle();
    endtask

    task automatic test_drop();
        idle(); net_polarity = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'h1; tick();
        d_in = 64'h2; tick();
        nicEn = 1'b0; #1;
        total += 2;
        if (net_do !== 64'h1) begin bad++; $display("FAIL drop_net_do: got %h want 1", net_do); end
        if (net_si !== 1'b1)  begin bad++; $display("FAIL drop_si: got %b want 1", net_si); end
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd2; tick();
        total++;
        if (d_out !== 64'h1) begin bad++; $display("FAIL drop_read_out: got %h want 1", d_out); end
        // Write while full, in the very cycle the entry drains: still dropped.
        nicWrEn = 1'b1; d_in = 64'h3; net_ri = 1'b1; tick();
        idle(); #1;
        total += 2;
        if (net_si !== 1'b0) begin bad++; $display("FAIL drain_drop_si: got %b want 0", net_si); end
        if (net_do !== 64'h1) begin bad++; $display("FAIL drain_drop_net_do: got %h want 1", net_do); end
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd3; tick();
        total++;
        if (d_out !== m_dout) begin bad++; $display("FAIL drop_out_status: got %h want %h", d_out, m_dout); end
        idle();
    endtask

    task automatic test_receive();
        idle(); net_so = 1'b1; net_di = 64'h55; #1;
        total++;
        if (net_ro !== 1'b1) begin bad++; $display("FAIL rx_ro_before: got %b want 1", net_ro); end
        tick();
        net_so = 1'b0; #1;
        total++;
        if (net_ro !== 1'b0) begin bad++; $display("FAIL rx_ro_after: got %b want 0", net_ro); end
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd1; tick();
        total += 2;
        if (d_out[0] !== 1'b1) begin bad++; $display("FAIL rx_in_full: got %b want 1", d_out[0]); end
        if (d_out !== m_dout)  begin bad++; $display("FAIL rx_in_status: got %h want %h", d_out, m_dout); end
        // Second router send while full must not be captured.
        nicEn = 1'b0; net_so = 1'b1; net_di = 64'h66; tick();
        net_so = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd0; tick();
        total += 2;
        if (d_out !== 64'h55) begin bad++; $display("FAIL rx_read_data: got %h want 55", d_out); end
        if (net_ro !== 1'b1)  begin bad++; $display("FAIL rx_ro_freed: got %b want 1", net_ro); end
        tick();
        total += 2;
        if (d_out !== 64'h55) begin bad++; $display("FAIL rx_stale_read: got %h want 55", d_out); end
        if (net_ro !== 1'b1)  begin bad++; $display("FAIL rx_stale_ro: got %b want 1", net_ro); end
        idle(); tick();
        total++;
        if (d_out !== 64'h55) begin bad++; $display("FAIL rx_dout_hold: got %h want 55", d_out); end
    endtask

    task automatic test_back_to_back();
        idle(); net_so = 1'b1; nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd0;
        for (int i = 0; i < 24; i++) begin
            net_di = {$urandom, $urandom};
            tick();
            total += 2;
            if (d_out !== m_dout)     begin bad++; $display("FAIL b2b_d_out[%0d]: got %h want %h", i, d_out, m_dout); end
            if (net_ro !== !m_in_full) begin bad++; $display("FAIL b2b_ro[%0d]: got %b want %b", i, net_ro, !m_in_full); end
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset        = ($urandom_range(0, 63) != 0);
            nicEn        = $urandom_range(0, 3) != 0;
            nicWrEn      = $urandom_range(0, 1) == 1;
            addr         = 2'($urandom_range(0, 3));
            d_in         = {$urandom, $urandom};
            net_ri       = $urandom_range(0, 1) == 1;
            net_so       = $urandom_range(0, 1) == 1;
            net_di       = {$urandom, $urandom};
            net_polarity = $urandom_range(0, 1) == 1;
            #1;
            total += 3;
            if (net_si !== m_si())      begin bad++; $display("FAIL rnd_si[%0d]: got %b want %b", i, net_si, m_si()); end
            if (net_ro !== !m_in_full)  begin bad++; $display("FAIL rnd_ro[%0d]: got %b want %b", i, net_ro, !m_in_full); end
            if (net_do !== m_out_buf)   begin bad++; $display("FAIL rnd_do[%0d]: got %h want %h", i, net_do, m_out_buf); end
            tick();
            total++;
            if (d_out !== m_dout) begin bad++; $display("FAIL rnd_d_out[%0d]: got %h want %h", i, d_out, m_dout); end
        end
        reset = 1'b1; idle();
    endtask

`ifdef NIC_PKT_CNT_EN
    task automatic test_counters();
        reset = 1'b0; idle(); tick(); reset = 1'b1;
        net_ri = 1'b1;
        for (int i = 0; i < 257; i++) begin
            nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2;
            d_in = {net_polarity, 63'(i)};
            tick();
            nicEn = 1'b0; tick();
        end
        net_ri = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd3; tick();
        total += 2;
        if (d_out[15:8] !== 8'h01) begin bad++; $display("FAIL cnt_sent_wrap: got %h want 01", d_out[15:8]); end
        if (d_out !== m_dout)      begin bad++; $display("FAIL cnt_out_status: got %h want %h", d_out, m_dout); end
        for (int i = 0; i < 3; i++) begin
            nicEn = 1'b0; net_so = 1'b1; net_di = 64'(i); tick();
            net_so = 1'b0; nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd0; tick();
        end
        addr = 2'd1; tick();
        total++;
        if (d_out[15:8] !== 8'd3) begin bad++; $display("FAIL cnt_rcvd: got %h want 03", d_out[15:8]); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_polarity();
        test_drop();
        test_receive();
        test_back_to_back();
`ifdef NIC_PKT_CNT_EN
        test_counters();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
